xbus_arbiter: RTL and testbench

Two-master, single-slave arbiter and sequencer for the core's external bus (xbus).
- M0 is the data-side load/store path; M1 is instruction fetch.
- Grants round-robin, latches the winning request and drives it onto xbus until the slave signals ready.
- Routes the response back to the owner and aborts on timeout.
- Sits between the core's memory-access units and the xbus fabric.

---
 rtl/xbus_arbiter_pkg.sv | 16 +
 rtl/xbus_arbiter_rr_arb2.sv | 32 +++
 rtl/xbus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_xbus_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/xbus_arbiter_pkg.sv
// xbus_arbiter_pkg
//   Shared definitions for the xbus arbiter:
//   - xa_state_e : sequencer state encoding (XA_IDLE / XA_BUSY)
//   - XA_M0/XA_M1: master indices, also used as the round-robin history value
package xbus_arbiter_pkg;

  typedef enum logic {
    XA_IDLE = 1'b0,
    XA_BUSY = 1'b1
  } xa_state_e;

  // M0 = data-side load/store path, M1 = instruction fetch
  localparam logic XA_M0 = 1'b0;
  localparam logic XA_M1 = 1'b1;

endpackage

// File: rtl/xbus_arbiter_rr_arb2.sv
// rr_arb2
//   Purely combinational two-way round-robin pick.
//   Ports:
//     req[1:0]   : request lines, bit i = master i
//     last_grant : index of the master that won the previous arbitration
//     gnt[1:0]   : one-hot grant (all zero when nothing requests)
//     grant      : index of the winner (meaningful only when |req)
module rr_arb2
  import xbus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       grant
);

  always_comb begin
    grant = XA_M0;
    gnt   = 2'b00;
    case (req)
      2'b01: grant = XA_M0;
      2'b10: grant = XA_M1;
      // On a tie the master that did not win last time goes first.
      2'b11: grant = (last_grant == XA_M1) ? XA_M0 : XA_M1;
      default: grant = XA_M0;
    endcase
    if (req != 2'b00) begin
      gnt = (grant == XA_M1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// xbus_arbiter
//   Two-master, single-slave arbiter/sequencer for the external bus.
//   M0 is the load/store path, M1 is instruction fetch. In IDLE a request is
//   picked round-robin and its fields are latched; in BUSY the latched
//   transfer is held on xbus until xbus_ready, or until TIMEOUT BUSY cycles
//   pass without it, in which case the owner gets ack+err.
//   Ports:
//     clk, rst                     : clock, synchronous active-high reset
//     m0_* / m1_*                  : master request side (req, we, be, addr,
//                                    wdata in; ack, err, rdata out)
//     xbus_valid/we/be/addr/wdata  : transfer presented to the slave
//     xbus_rdata, xbus_ready       : slave response
//     busy                         : sequencer is in BUSY
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              xbus_valid,
  output logic              xbus_we,
  output logic [3:0]        xbus_be,
  output logic [ADDR_W-1:0] xbus_addr,
  output logic [DATA_W-1:0] xbus_wdata,
  input  logic [DATA_W-1:0] xbus_rdata,
  input  logic              xbus_ready,
  output logic              busy
);

  // The counter only has to reach TIMEOUT-1.
  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  xa_state_e         state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg, we_next;
  logic [3:0]        be_reg, be_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;

  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  logic              grant_idx;

  logic              resp_ack;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  assign req_vec = {m1_req, m0_req};

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last_grant (last_grant_reg),
    .gnt        (gnt),
    .grant      (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= XA_IDLE;
      owner_reg      <= XA_M0;
      last_grant_reg <= XA_M1;
      cnt_reg        <= '0;
      we_reg         <= 1'b0;
      be_reg         <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      we_reg         <= we_next;
      be_reg         <= be_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    we_next         = we_reg;
    be_next         = be_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    resp_ack        = 1'b0;
    resp_err        = 1'b0;
    resp_rdata      = '0;

    case (state_reg)
      XA_IDLE: begin
        if (req_vec != 2'b00) begin
          state_next      = XA_BUSY;
          owner_next      = grant_idx;
          last_grant_next = grant_idx;
          cnt_next        = '0;
          we_next         = gnt[1] ? m1_we    : m0_we;
          be_next         = gnt[1] ? m1_be    : m0_be;
          addr_next       = gnt[1] ? m1_addr  : m0_addr;
          wdata_next      = gnt[1] ? m1_wdata : m0_wdata;
        end
      end
      XA_BUSY: begin
        // Ready is checked first so it wins over a same-cycle timeout.
        if (xbus_ready) begin
          resp_ack   = 1'b1;
          resp_rdata = xbus_rdata;
          state_next = XA_IDLE;
          cnt_next   = '0;
        end else if (TO_EN && (cnt_reg == TO_LAST)) begin
          resp_ack   = 1'b1;
          resp_err   = 1'b1;
          state_next = XA_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = XA_IDLE;
    endcase
  end

  assign busy       = (state_reg == XA_BUSY);
  assign xbus_valid = busy;
  assign xbus_we    = we_reg;
  assign xbus_be    = be_reg;
  assign xbus_addr  = addr_reg;
  assign xbus_wdata = wdata_reg;

  // Response is steered to the owner only; the other master sees zeros.
  assign m0_ack   = resp_ack & (owner_reg == XA_M0);
  assign m0_err   = resp_err & (owner_reg == XA_M0);
  assign m0_rdata = (owner_reg == XA_M0) ? resp_rdata : '0;
  assign m1_ack   = resp_ack & (owner_reg == XA_M1);
  assign m1_err   = resp_err & (owner_reg == XA_M1);
  assign m1_rdata = (owner_reg == XA_M1) ? resp_rdata : '0;

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter
//   Directed, table-driven bench for xbus_arbiter (TIMEOUT=4). Each table
//   row is one clock cycle: inputs are applied just after the rising edge
//   and outputs are compared on the falling edge of the same cycle.
module tb_xbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // ctl = {xbus_valid, busy, m0_ack, m0_err, m1_ack, m1_err}
  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_BUSY = 6'b110000;
  localparam logic [5:0] C_A0   = 6'b111000;
  localparam logic [5:0] C_E0   = 6'b111100;
  localparam logic [5:0] C_A1   = 6'b110010;

  // bus check selector
  localparam logic [1:0] B_NONE = 2'd0;
  localparam logic [1:0] B_M0   = 2'd1;
  localparam logic [1:0] B_M1   = 2'd2;
  localparam logic [1:0] B_ZERO = 2'd3;

  // Fixed master request fields; bus = {we, be, addr, wdata}
  localparam logic [68:0] BUS_M0 = {1'b0, 4'hF, 32'h1000_0004, 32'h1111_1111};
  localparam logic [68:0] BUS_M1 = {1'b1, 4'hC, 32'h2000_0008, 32'hABCD_0000};

  typedef struct {
    logic        rst;
    logic        m0r;
    logic        m1r;
    logic        rdy;
    logic [31:0] rdata;
    logic [5:0]  ctl;
    logic [1:0]  bus;
    logic [31:0] m0rd;
    logic [31:0] m1rd;
  } vec_t;

  localparam int NV = 40;
  vec_t tbl [NV];

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [3:0]    m0_be, m1_be;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          xbus_valid, xbus_we, xbus_ready, busy;
  logic [3:0]    xbus_be;
  logic [AW-1:0] xbus_addr;
  logic [DW-1:0] xbus_wdata, xbus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_be      (m0_be),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_be      (m1_be),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .m1_rdata   (m1_rdata),
    .xbus_valid (xbus_valid),
    .xbus_we    (xbus_we),
    .xbus_be    (xbus_be),
    .xbus_addr  (xbus_addr),
    .xbus_wdata (xbus_wdata),
    .xbus_rdata (xbus_rdata),
    .xbus_ready (xbus_ready),
    .busy       (busy)
  );

  function automatic vec_t mk(input logic r, input logic a, input logic b,
                              input logic y, input logic [31:0] d,
                              input logic [5:0] c, input logic [1:0] s,
                              input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.rst = r; v.m0r = a; v.m1r = b; v.rdy = y; v.rdata = d;
    v.ctl = c; v.bus = s; v.m0rd = e0; v.m1rd = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [68:0] exp_bus;
    int          n;
    bit          seen;

    // row: rst m0 m1 rdy rdata          ctl     bus     m0rd          m1rd
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,        C_IDLE, B_ZERO, 32'h0,        32'h0);
    // single M0 read, ready on 2nd BUSY cycle
    tbl[1]  = mk(0, 1, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[2]  = mk(0, 1, 0, 0, 32'h0,        C_BUSY, B_M0,   32'h0,        32'h0);
    tbl[3]  = mk(0, 1, 0, 1, 32'hDEADBEEF, C_A0,   B_M0,   32'hDEADBEEF, 32'h0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    // reset, then tie: M0 first, then M1 write
    tbl[5]  = mk(1, 0, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[6]  = mk(0, 1, 1, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[7]  = mk(0, 1, 1, 1, 32'hA0,       C_A0,   B_M0,   32'hA0,       32'h0);
    tbl[8]  = mk(0, 0, 1, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[9]  = mk(0, 0, 1, 0, 32'h0,        C_BUSY, B_M1,   32'h0,        32'h0);
    tbl[10] = mk(0, 0, 1, 1, 32'h12345678, C_A1,   B_M1,   32'h0,        32'h12345678);
    tbl[11] = mk(0, 0, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    // both held: M0, M1, M0, 3 cycles each
    tbl[12] = mk(0, 1, 1, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[13] = mk(0, 1, 1, 0, 32'h0,        C_BUSY, B_M0,   32'h0,        32'h0);
    tbl[14] = mk(0, 1, 1, 1, 32'h0A,       C_A0,   B_M0,   32'h0A,       32'h0);
    tbl[15] = mk(0, 1, 1, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[16] = mk(0, 1, 1, 0, 32'h0,        C_BUSY, B_M1,   32'h0,        32'h0);
    tbl[17] = mk(0, 1, 1, 1, 32'h0B,       C_A1,   B_M1,   32'h0,        32'h0B);
    tbl[18] = mk(0, 1, 1, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[19] = mk(0, 1, 1, 0, 32'h0,        C_BUSY, B_M0,   32'h0,        32'h0);
    tbl[20] = mk(0, 1, 1, 1, 32'h0C,       C_A0,   B_M0,   32'h0C,       32'h0);
    // ready in IDLE is ignored
    tbl[21] = mk(0, 0, 0, 1, 32'hFFFFFFFF, C_IDLE, B_NONE, 32'h0,        32'h0);
    // timeout on 4th BUSY cycle, rdata forced to 0
    tbl[22] = mk(0, 1, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[23] = mk(0, 1, 0, 0, 32'h55555555, C_BUSY, B_M0,   32'h0,        32'h0);
    tbl[24] = mk(0, 1, 0, 0, 32'h55555555, C_BUSY, B_M0,   32'h0,        32'h0);
    tbl[25] = mk(0, 1, 0, 0, 32'h55555555, C_BUSY, B_M0,   32'h0,        32'h0);
    tbl[26] = mk(0, 1, 0, 0, 32'h55555555, C_E0,   B_M0,   32'h0,        32'h0);
    tbl[27] = mk(0, 0, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    // ready on the timeout cycle wins
    tbl[28] = mk(0, 0, 1, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[29] = mk(0, 0, 1, 0, 32'h0,        C_BUSY, B_M1,   32'h0,        32'h0);
    tbl[30] = mk(0, 0, 1, 0, 32'h0,        C_BUSY, B_M1,   32'h0,        32'h0);
    tbl[31] = mk(0, 0, 1, 0, 32'h0,        C_BUSY, B_M1,   32'h0,        32'h0);
    tbl[32] = mk(0, 0, 1, 1, 32'h77,       C_A1,   B_M1,   32'h0,        32'h77);
    tbl[33] = mk(0, 0, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    // reset in 2nd BUSY cycle of an M0 transfer; next tie goes to M0
    tbl[34] = mk(0, 1, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[35] = mk(0, 1, 0, 0, 32'h0,        C_BUSY, B_M0,   32'h0,        32'h0);
    tbl[36] = mk(1, 1, 0, 0, 32'h0,        C_BUSY, B_M0,   32'h0,        32'h0);
    tbl[37] = mk(0, 1, 1, 1, 32'h99,       C_IDLE, B_NONE, 32'h0,        32'h0);
    tbl[38] = mk(0, 1, 1, 1, 32'h99,       C_A0,   B_M0,   32'h99,       32'h0);
    tbl[39] = mk(0, 0, 0, 0, 32'h0,        C_IDLE, B_NONE, 32'h0,        32'h0);

    m0_we = 1'b0; m0_be = 4'hF; m0_addr = 32'h1000_0004; m0_wdata = 32'h1111_1111;
    m1_we = 1'b1; m1_be = 4'hC; m1_addr = 32'h2000_0008; m1_wdata = 32'hABCD_0000;
    m0_req = 1'b0; m1_req = 1'b0; xbus_ready = 1'b0; xbus_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      #1;
      rst        = tbl[i].rst;
      m0_req     = tbl[i].m0r;
      m1_req     = tbl[i].m1r;
      xbus_ready = tbl[i].rdy;
      xbus_rdata = tbl[i].rdata;
      @(negedge clk);
      check($sformatf("row%0d ctl", i),
            69'({xbus_valid, busy, m0_ack, m0_err, m1_ack, m1_err}), 69'(tbl[i].ctl));
      check($sformatf("row%0d m0_rdata", i), 69'(m0_rdata), 69'(tbl[i].m0rd));
      check($sformatf("row%0d m1_rdata", i), 69'(m1_rdata), 69'(tbl[i].m1rd));
      if (tbl[i].bus != B_NONE) begin
        exp_bus = (tbl[i].bus == B_M0) ? BUS_M0 : (tbl[i].bus == B_M1) ? BUS_M1 : 69'h0;
        check($sformatf("row%0d xbus", i),
              {xbus_we, xbus_be, xbus_addr, xbus_wdata}, exp_bus);
      end
      $display("row %0d: rst=%0b req=%0b%0b rdy=%0b valid=%0b ack=%0b%0b err=%0b%0b addr=%h",
               i, rst, m1_req, m0_req, xbus_ready, xbus_valid, m1_ack, m0_ack,
               m1_err, m0_err, xbus_addr);
      @(posedge clk);
    end

    // Minimum latency with ready tied high: ack one cycle after the request
    // cycle, with a bounded wait.
    #1;
    m1_req = 1'b1; xbus_ready = 1'b1; xbus_rdata = 32'h31;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      if (m1_ack) begin
        seen = 1'b1;
      end else begin
        n++;
        @(posedge clk); #1;
      end
    end
    check("latency ack seen", 69'(seen), 69'(1'b1));
    check("latency cycles", 69'(n), 69'(1));
    check("latency m1_rdata", 69'(m1_rdata), 69'(32'h31));
    check("latency m0_ack", 69'(m0_ack), 69'(1'b0));
    $display("latency seq: ack=%0b cycles=%0d rdata=%h", seen, n, m1_rdata);
    @(posedge clk); #1;
    m1_req = 1'b0; xbus_ready = 1'b0;
    @(negedge clk);
    check("post-ack idle", 69'({xbus_valid, busy, m1_ack}), 69'(3'b000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
